// File: rtl/sm_arith_pkg.sv
// sm_arith_pkg: shared FSM encoding, opcode constants and sign-magnitude field helpers
//   used by sm_addsub_seq and sm_mag_unit.
package sm_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Helpers take a 64-bit carrier plus the live width so one definition serves every WIDTH.
    function automatic logic sm_sign(input logic [63:0] x, input int w);
        return x[6'(w - 1)];
    endfunction

    function automatic logic [63:0] sm_mag(input logic [63:0] x, input int w);
        return x & ((64'd1 << (w - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/sm_mag_unit.sv
// sm_mag_unit: combinational magnitude compare and add / larger-minus-smaller subtract.
//   i_x, i_y : MW-bit magnitudes
//   i_add    : 1 = o_res is i_x+i_y, 0 = o_res is |i_x-i_y|
//   o_ge     : i_x >= i_y
//   o_eq     : i_x == i_y
//   o_res    : MW+1-bit result, wide enough that the sum never wraps
module sm_mag_unit #(
    parameter int MW = 17
) (
    input  logic [MW-1:0] i_x,
    input  logic [MW-1:0] i_y,
    input  logic          i_add,
    output logic          o_ge,
    output logic          o_eq,
    output logic [MW:0]   o_res
);

    always_comb begin
        o_ge  = i_x >= i_y;
        o_eq  = i_x == i_y;
        o_res = i_add ? {1'b0, i_x} + {1'b0, i_y}
              : o_ge  ? {1'b0, i_x - i_y}
              :         {1'b0, i_y - i_x};
    end

endmodule

// File: rtl/sm_addsub_seq.sv
// sm_addsub_seq: sequential sign-magnitude a-b / a+b with valid/ready at both ends.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   op                  : 0 = a-b, 1 = a+b
//   a, b                : WIDTH-bit sign-magnitude operands (MSB = sign)
//   out_valid/out_ready : result handshake
//   z                   : WIDTH+1-bit result (MSB = sign, never -0)
//   z_zero              : result magnitude is zero
//   busy                : unit is not in IDLE
module sm_addsub_seq
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   z,
    output logic             z_zero,
    output logic             busy
);

    localparam int MW = WIDTH - 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_same;
    logic             r_ge;
    logic             r_eq;
    logic             r_eff_bs;

    logic [MW-1:0]    w_a_mag;
    logic [MW-1:0]    w_b_mag;
    logic             w_a_sign;
    logic             w_eff_bs;
    logic             w_ge;
    logic             w_eq;
    logic [MW:0]      w_cmp_res;
    logic             w_calc_ge;
    logic             w_calc_eq;
    logic [MW:0]      w_calc_res;
    logic             w_zero;
    logic             w_sign;
    logic             w_unused;

    assign w_a_mag  = MW'(sm_mag(64'(r_a), WIDTH));
    assign w_b_mag  = MW'(sm_mag(64'(r_b), WIDTH));
    assign w_a_sign = sm_sign(64'(r_a), WIDTH);
    // Subtraction is addition of b with its sign flipped.
    assign w_eff_bs = sm_sign(64'(r_b), WIDTH) ^ (r_op == OP_SUB);

    sm_mag_unit #(.MW(MW)) u_cmp (
        .i_x   (w_a_mag),
        .i_y   (w_b_mag),
        .i_add (1'b0),
        .o_ge  (w_ge),
        .o_eq  (w_eq),
        .o_res (w_cmp_res)
    );

    sm_mag_unit #(.MW(MW)) u_calc (
        .i_x   (w_a_mag),
        .i_y   (w_b_mag),
        .i_add (r_same),
        .o_ge  (w_calc_ge),
        .o_eq  (w_calc_eq),
        .o_res (w_calc_res)
    );

    assign w_unused = ^{w_cmp_res, w_calc_ge, w_calc_eq};

    // A sum is zero only when both magnitudes are; a difference is zero exactly when they match.
    assign w_zero = r_same ? (w_calc_res == '0) : r_eq;
    // Forcing the sign low on zero also turns -0 operands into a canonical +0.
    assign w_sign = w_zero ? 1'b0 : (r_same || r_ge) ? w_a_sign : r_eff_bs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 1'b0;
            r_same    <= 1'b0;
            r_ge      <= 1'b0;
            r_eq      <= 1'b0;
            r_eff_bs  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            z         <= '0;
            z_zero    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_op     <= op;
                    r_state  <= ST_CMP;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                ST_CMP: begin
                    r_same   <= w_a_sign == w_eff_bs;
                    r_ge     <= w_ge;
                    r_eq     <= w_eq;
                    r_eff_bs <= w_eff_bs;
                    r_state  <= ST_CALC;
                end
                ST_CALC: begin
                    z         <= {w_sign, w_calc_res};
                    z_zero    <= w_zero;
                    out_valid <= 1'b1;
                    r_state   <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_addsub_seq.sv
// tb_sm_addsub_seq: directed vectors with a scoreboard queue and an independent output monitor.
module tb_sm_addsub_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [17:0] a = '0;
    logic [17:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [18:0] z;
    logic        z_zero;
    logic        busy;

    int          nvec = 0;
    int          nfail = 0;
    logic [19:0] sb[$];
    logic [19:0] exp_e;

    sm_addsub_seq #(.WIDTH(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .z_zero    (z_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] sm(input logic s, input int m);
        return {s, 17'(m)};
    endfunction

    function automatic logic [19:0] ex(input logic s, input int m, input logic zz);
        return {zz, s, 18'(m)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic issue(input logic o, input logic [17:0] xa, input logic [17:0] xb, input logic [19:0] e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++;
            nfail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
            return;
        end
        op = o;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 1'($urandom);
        a = 18'($urandom);
        b = 18'($urandom);
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            nvec++;
            nfail++;
            $display("FAIL %s: out_valid not seen within %0d cycles", nm, n);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL sb_unexpected: got z=%0h with no result pending", z);
            end else begin
                exp_e = sb.pop_front();
                chk("sb_z", 64'(z), 64'(exp_e[18:0]));
                chk("sb_zero", 64'(z_zero), 64'(exp_e[19]));
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_z_zero", 64'(z_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // T1: latency counted from the acceptance edge
        issue(1'b0, sm(0, 5), sm(0, 3), ex(0, 2, 0));
        wait_valid("t1_wait", n);
        chk("t1_latency", 64'(n), 64'd3);

        // T2
        issue(1'b0, sm(0, 3), sm(0, 5), ex(1, 2, 0));
        issue(1'b1, sm(1, 3), sm(0, 5), ex(0, 2, 0));
        // T3: magnitude grows to the full 18 bits
        issue(1'b0, sm(0, 131071), sm(1, 131071), ex(0, 262142, 0));
        // T4: zero results, including -0 operand
        issue(1'b0, sm(1, 7), sm(1, 7), ex(0, 0, 1));
        issue(1'b1, sm(1, 0), sm(0, 0), ex(0, 0, 1));
        issue(1'b1, sm(1, 100), sm(1, 28), ex(1, 128, 0));

        // T5: hold in DONE, intruding in_valid must be ignored
        @(negedge clk);
        while (busy) @(negedge clk);
        out_ready = 1'b0;
        issue(1'b0, sm(0, 100), sm(0, 1), ex(0, 99, 0));
        wait_valid("t5_wait", n);
        #1;
        op = 1'b1;
        a = sm(0, 11);
        b = sm(0, 22);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(out_valid), 64'd1);
            chk("t5_hold_in_ready", 64'(in_ready), 64'd0);
            chk("t5_hold_z", 64'(z), 64'(19'h00063));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle_valid", 64'(out_valid), 64'd0);
        chk("t5_idle_ready", 64'(in_ready), 64'd1);
        chk("t5_z_kept", 64'(z), 64'(19'h00063));

        // T6: reset while in CALC drops the operation
        issue(1'b0, sm(0, 50), sm(0, 1), ex(0, 49, 0));
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd1);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_z", 64'(z), 64'd0);
        chk("t6_rst_zero", 64'(z_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_valid", 64'(out_valid), 64'd0);
        end
        issue(1'b0, sm(0, 9), sm(0, 4), ex(0, 5, 0));

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
